// File: rtl/cog_pkg.sv
// -----------------------------------------------------------------------------
// cog_pkg
// Shared types and constants for the CoG transmitter slice.
//   cog_entry_t     : one FIFO entry captured from the processing stage
//   cog_state_t     : transmitter FSM states
//   POINT_FLAG      : tdata bit that marks a point word
//   EMPTY_TERM_WORD : base value of a line terminator word
// -----------------------------------------------------------------------------
package cog_pkg;

  localparam int          POINT_FLAG      = 15;
  localparam logic [15:0] EMPTY_TERM_WORD = 16'h0000;

  typedef struct packed {
    logic        has_pt;
    logic        line_end;
    logic [29:0] sum_icoord;
    logic [22:0] sum_i;
    logic [10:0] start_point;
  } cog_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_PT_OUT,
    ST_TERM_OUT
  } cog_state_t;

endpackage

// File: rtl/cog_divider.sv
// -----------------------------------------------------------------------------
// cog_divider
// Sequential restoring divider, one quotient bit per clock, NUM_W iterations.
// Ports:
//   i_sys_clk, i_sys_aresetn : clock, async active-low reset
//   i_start                  : load operands and begin (ignored while busy)
//   i_num, i_den             : numerator / denominator
//   o_busy                   : iterations in progress
//   o_done                   : high during the final iteration; the complete
//                              quotient is registered on that clock edge
//   o_div_by_zero            : denominator of the last division was zero
//   o_quotient               : low QUO_W bits of the quotient, held until the
//                              next start
// -----------------------------------------------------------------------------
module cog_divider #(
  parameter int NUM_W = 34,
  parameter int DEN_W = 23,
  parameter int QUO_W = 15
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_aresetn,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [QUO_W-1:0] o_quotient
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [DEN_W-1:0] r_rem;
  logic [DEN_W-1:0] r_den;
  logic [NUM_W-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_dbz;

  logic [DEN_W:0]   w_trial;
  logic [DEN_W-1:0] w_diff;
  logic             w_ge;
  logic             w_last;

  // r_quo starts as the numerator: its MSB is shifted into the partial
  // remainder while the new quotient bit enters at the LSB.
  assign w_trial = {r_rem, r_quo[NUM_W-1]};
  assign w_ge    = (w_trial >= {1'b0, r_den});
  assign w_diff  = w_trial[DEN_W-1:0] - r_den;
  assign w_last  = r_busy && (r_cnt == CNT_W'(NUM_W - 1));

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_rem  <= '0;
      r_den  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_rem  <= '0;
      r_den  <= i_den;
      r_quo  <= i_num;
      r_cnt  <= '0;
      r_busy <= 1'b1;
      r_dbz  <= (i_den == '0);
    end else if (r_busy) begin
      r_rem <= w_ge ? w_diff : w_trial[DEN_W-1:0];
      r_quo <= {r_quo[NUM_W-2:0], w_ge};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = w_last;
  assign o_div_by_zero = r_dbz;
  assign o_quotient    = r_quo[QUO_W-1:0];

endmodule

// File: rtl/cog_transmitter.sv
// -----------------------------------------------------------------------------
// cog_transmitter
// Buffers per-figure sums and line markers, computes each figure's
// centre-of-gravity coordinate (fixed point, FRAC_BITS fraction bits) and
// streams one word per figure plus a per-line terminator over AXI4-Stream.
// Ports:
//   i_sys_clk, i_sys_aresetn  : clock, async active-low reset
//   i_sum_of_I_mult_coord     : sum(I^2 * coord), coord 1-based in figure
//   i_sum_of_I                : sum(I^2)
//   i_start_point             : first column of the figure
//   i_point_is_valid          : sums/start point valid this cycle
//   i_end_of_line/_frame      : line / frame end strobes
//   i_new_frame               : frame start strobe (arms tuser, clears drops)
//   m_axis_*                  : AXI4-Stream master
//   o_overflow                : sticky "entry dropped" flag
// Optional build macro COG_DROP_COUNTER_EN adds o_drop_cnt[15:0].
// -----------------------------------------------------------------------------
module cog_transmitter
  import cog_pkg::*;
#(
  parameter int FRAC_BITS  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_sys_clk,
  input  logic        i_sys_aresetn,
  input  logic [29:0] i_sum_of_I_mult_coord,
  input  logic [22:0] i_sum_of_I,
  input  logic [10:0] i_start_point,
  input  logic        i_point_is_valid,
  input  logic        i_end_of_line,
  input  logic        i_end_of_frame,
  input  logic        i_new_frame,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        o_overflow
`ifdef COG_DROP_COUNTER_EN
  ,
  output logic [15:0] o_drop_cnt
`endif
);

  localparam int          NUM_W      = 30 + FRAC_BITS;
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH    = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] C_DEPTH_M1 = C_DEPTH - 1'b1;
  localparam logic [14:0] C_ONE      = 15'd1 << FRAC_BITS;

  cog_state_t r_state, w_next_state;

  cog_entry_t r_mem [FIFO_DEPTH];
  cog_entry_t w_entry;
  cog_entry_t w_head;
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_occ;
  logic        w_empty, w_line_end, w_push_req, w_admit, w_push, w_drop, w_pop;

  logic             w_div_start, w_div_busy, w_div_done, w_div_dbz;
  logic [NUM_W-1:0] w_div_num;
  logic [14:0]      w_div_quo, w_q, w_start_sh, w_coord;

  logic        r_cur_line_end;
  logic [10:0] r_cur_start;
  logic [7:0]  r_line_cnt;
  logic        r_sof_pending, r_tuser, r_overflow;
  logic        w_hs, w_sof_next;

  // ---------------- entry FIFO ----------------
  // End-of-frame always coincides with end-of-line; OR-ing it in is harmless.
  assign w_line_end = i_end_of_line | i_end_of_frame;
  assign w_entry    = '{has_pt:      i_point_is_valid,
                        line_end:    w_line_end,
                        sum_icoord:  i_sum_of_I_mult_coord,
                        sum_i:       i_sum_of_I,
                        start_point: i_start_point};

  assign w_occ      = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_occ == '0);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_push_req = i_point_is_valid | w_line_end;
  // The last slot is reserved for a line marker so a flood of points can
  // never swallow the terminator. A same-cycle pop does not free a slot.
  assign w_admit    = w_line_end ? (w_occ < C_DEPTH) : (w_occ < C_DEPTH_M1);
  assign w_push     = w_push_req & w_admit;
  assign w_drop     = w_push_req & ~w_admit;

  always_ff @(posedge i_sys_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------- divider ----------------
  assign w_div_num = NUM_W'(w_head.sum_icoord) << FRAC_BITS;

  cog_divider #(
    .NUM_W (NUM_W),
    .DEN_W (23),
    .QUO_W (15)
  ) u_divider (
    .i_sys_clk     (i_sys_clk),
    .i_sys_aresetn (i_sys_aresetn),
    .i_start       (w_div_start),
    .i_num         (w_div_num),
    .i_den         (w_head.sum_i),
    .o_busy        (w_div_busy),
    .o_done        (w_div_done),
    .o_div_by_zero (w_div_dbz),
    .o_quotient    (w_div_quo)
  );

  // Coordinate is 1-based inside the figure, hence the subtraction of one.
  // A zero weight yields the figure's start column.
  assign w_q        = w_div_dbz ? C_ONE : w_div_quo;
  assign w_start_sh = 15'(r_cur_start) << FRAC_BITS;
  assign w_coord    = w_start_sh + w_q - C_ONE;

  // ---------------- FSM ----------------
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_div_start   = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty && !w_div_busy) begin
          w_pop = 1'b1;
          if (w_head.has_pt) begin
            w_div_start  = 1'b1;
            w_next_state = ST_DIV;
          end else begin
            w_next_state = ST_TERM_OUT;
          end
        end
      end
      ST_DIV: begin
        if (w_div_done) w_next_state = ST_PT_OUT;
      end
      ST_PT_OUT: begin
        m_axis_tvalid            = 1'b1;
        m_axis_tdata[POINT_FLAG] = 1'b1;
        m_axis_tdata[14:0]       = w_coord;
        if (m_axis_tready) w_next_state = r_cur_line_end ? ST_TERM_OUT : ST_IDLE;
      end
      ST_TERM_OUT: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = EMPTY_TERM_WORD | {8'h00, r_line_cnt};
        if (m_axis_tready) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // ---------------- stream side state ----------------
  assign w_hs = m_axis_tvalid & m_axis_tready;
  // tuser is frozen while a word waits, so a new_frame arriving mid-stall
  // marks the following word rather than changing the stalled one.
  assign w_sof_next   = i_new_frame ? 1'b1 : ((w_hs && r_tuser) ? 1'b0 : r_sof_pending);
  assign m_axis_tuser = m_axis_tvalid & r_tuser;
  assign o_overflow   = r_overflow;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_cur_line_end <= 1'b0;
      r_cur_start    <= '0;
      r_line_cnt     <= '0;
      r_sof_pending  <= 1'b0;
      r_tuser        <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      if (w_pop) begin
        r_cur_line_end <= w_head.line_end;
        r_cur_start    <= w_head.start_point;
      end
      if (w_hs && r_state == ST_TERM_OUT) begin
        r_line_cnt <= '0;
      end else if (w_hs && r_state == ST_PT_OUT && r_line_cnt != 8'hFF) begin
        r_line_cnt <= r_line_cnt + 1'b1;
      end
      r_sof_pending <= w_sof_next;
      if (!(m_axis_tvalid && !m_axis_tready)) begin
        r_tuser <= w_sof_next;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_new_frame) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef COG_DROP_COUNTER_EN
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_drop_cnt <= '0;
    end else if (i_new_frame) begin
      r_drop_cnt <= {15'd0, w_drop};
    end else if (w_drop && r_drop_cnt != 16'hFFFF) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_cog_transmitter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cog_transmitter
// Table-driven and hand-sequenced stimulus with a queue scoreboard for
// cog_transmitter (FRAC_BITS=4, FIFO_DEPTH=8).
// -----------------------------------------------------------------------------
module tb_cog_transmitter;

  localparam int F     = 4;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [29:0] sumIc = '0;
  logic [22:0] sumI = '0;
  logic [10:0] startPt = '0;
  logic        pointValid = 1'b0;
  logic        endOfLine = 1'b0;
  logic        endOfFrame = 1'b0;
  logic        newFrame = 1'b0;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tlast;
  logic        tuser;
  logic        overflow;
`ifdef COG_DROP_COUNTER_EN
  logic [15:0] dropCnt;
`endif

  cog_transmitter #(.FRAC_BITS(F), .FIFO_DEPTH(DEPTH)) dut (
    .i_sys_clk             (clk),
    .i_sys_aresetn         (rstn),
    .i_sum_of_I_mult_coord (sumIc),
    .i_sum_of_I            (sumI),
    .i_start_point         (startPt),
    .i_point_is_valid      (pointValid),
    .i_end_of_line         (endOfLine),
    .i_end_of_frame        (endOfFrame),
    .i_new_frame           (newFrame),
    .m_axis_tdata          (tdata),
    .m_axis_tvalid         (tvalid),
    .m_axis_tready         (tready),
    .m_axis_tlast          (tlast),
    .m_axis_tuser          (tuser),
    .o_overflow            (overflow)
`ifdef COG_DROP_COUNTER_EN
    ,
    .o_drop_cnt            (dropCnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic        eol;
    logic [29:0] sic;
    logic [22:0] si;
    logic [10:0] sp;
    logic [15:0] expPt;
  } vec_t;

  vec_t        vecs[8];
  logic [17:0] expQ[$];
  int          checks = 0;
  int          failures = 0;
  int          lineCnt = 0;
  logic        tbSof = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference coordinate computed with plain integer division.
  function automatic logic [15:0] modelPoint(input logic [29:0] sic, input logic [22:0] si,
                                             input logic [10:0] sp);
    longint unsigned num, q, c;
    num = sic;
    num = num << F;
    if (si == 0) q = 64'd1 << F;
    else         q = num / si;
    c = (longint'(sp) << F) + q - (64'd1 << F);
    return {1'b1, c[14:0]};
  endfunction

  task automatic pushWord(input logic [15:0] w, input logic last);
    expQ.push_back({tbSof, last, w});
    tbSof = 1'b0;
  endtask

  // Drives one cycle of inputs; called and returns at posedge+1.
  task automatic applyStimulus(input logic pv, input logic eol, input logic nf,
                               input logic [29:0] sic, input logic [22:0] si, input logic [10:0] sp);
    pointValid = pv;
    endOfLine  = eol;
    newFrame   = nf;
    sumIc      = sic;
    sumI       = si;
    startPt    = sp;
    @(posedge clk); #1;
    pointValid = 1'b0;
    endOfLine  = 1'b0;
    newFrame   = 1'b0;
  endtask

  task automatic driveRecord(input vec_t v);
    if (v.pv) begin
      pushWord(v.expPt, 1'b0);
      if (lineCnt < 255) lineCnt++;
    end
    if (v.eol) begin
      pushWord({8'h00, 8'(lineCnt)}, 1'b1);
      lineCnt = 0;
    end
    applyStimulus(v.pv, v.eol, 1'b0, v.sic, v.si, v.sp);
  endtask

  task automatic waitDrain(input int bound, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic waitValid(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tvalid && n < bound);
  endtask

  // Scoreboard: every accepted word is popped and compared.
  always @(negedge clk) begin
    if (rstn && tvalid && tready) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_word: actual=0x%0h with nothing expected", {tuser, tlast, tdata});
      end else begin
        logic [17:0] e;
        e = expQ.pop_front();
        checkOutput("stream_word", {14'd0, tuser, tlast, tdata}, {14'd0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int stable;
    vec_t rv;

    vecs[0] = '{1'b1, 1'b0, 30'd600,         23'd200,  11'd100,  16'h8660};
    vecs[1] = '{1'b0, 1'b1, 30'd0,           23'd0,    11'd0,    16'h0000};
    vecs[2] = '{1'b1, 1'b1, 30'd650,         23'd200,  11'd100,  16'h8664};
    vecs[3] = '{1'b0, 1'b1, 30'd0,           23'd0,    11'd0,    16'h0000};
    vecs[4] = '{1'b1, 1'b0, 30'd0,           23'd0,    11'd50,   16'h8320};
    vecs[5] = '{1'b1, 1'b0, 30'd1000,        23'd100,  11'd10,   16'h8130};
    vecs[6] = '{1'b1, 1'b0, 30'd4096,        23'd1024, 11'd2047, 16'h8020};
    vecs[7] = '{1'b1, 1'b1, 30'h3FFF_FFFF,   23'd1,    11'd0,    16'hFFE0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", tvalid, 0);
    checkOutput("reset_tdata", tdata, 0);
    checkOutput("reset_tlast", tlast, 0);
    checkOutput("reset_tuser", tuser, 0);
    checkOutput("reset_overflow", overflow, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table-driven lines
    for (int i = 0; i < 8; i++) begin
      driveRecord(vecs[i]);
      repeat (2) @(posedge clk);
      #1;
    end
    waitDrain(2000, "table_drain");

    // Random points, each with its own line end
    for (int i = 0; i < 6; i++) begin
      rv.pv    = 1'b1;
      rv.eol   = 1'b1;
      rv.sic   = 30'($urandom());
      rv.si    = 23'($urandom_range(32'h7F_FFFF, 1));
      rv.sp    = 11'($urandom());
      rv.expPt = modelPoint(rv.sic, rv.si, rv.sp);
      driveRecord(rv);
      waitDrain(200, "random_drain");
    end

    // Marker-only latency: nothing at +1 cycle, terminator at +2
    pushWord(16'h0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("marker_lat_c1", tvalid, 0);
    @(negedge clk);
    checkOutput("marker_lat_c2", tvalid, 1);
    @(posedge clk); #1;
    waitDrain(50, "marker_drain");

    // Point latency from an empty FIFO
    pushWord(16'h8660, 1'b0);
    pushWord(16'h0001, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 30'd600, 23'd200, 11'd100);
    waitValid(100, n);
    checkOutput("point_latency", n, 36);
    @(posedge clk); #1;
    waitDrain(50, "latency_drain");

    // Backpressure during PT_OUT
    tready = 1'b0;
    pushWord(16'h8660, 1'b0);
    pushWord(16'h0001, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd600, 23'd200, 11'd100);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    waitValid(100, n);
    checkOutput("bp_valid", tvalid, 1);
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tvalid !== 1'b1 || tdata !== 16'h8660 || tlast !== 1'b0) stable = 0;
    end
    checkOutput("bp_hold", stable, 1);
    @(posedge clk); #1;
    tready = 1'b1;
    waitDrain(50, "bp_drain");

    // Frame start: tuser on first accepted word only
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
    tbSof = 1'b1;
    driveRecord('{1'b1, 1'b1, 30'd0, 23'd0, 11'd50, 16'h8320});
    driveRecord('{1'b0, 1'b1, 30'd0, 23'd0, 11'd0, 16'h0000});
    waitDrain(200, "frame_drain");

    // Overflow with a stalled consumer
    checkOutput("ovf_before", overflow, 0);
    tready = 1'b0;
    pushWord(16'h8660, 1'b0);
    lineCnt = 1;
    applyStimulus(1'b1, 1'b0, 1'b0, 30'd600, 23'd200, 11'd100);
    waitValid(100, n);
    checkOutput("ovf_stall_valid", tvalid, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i < DEPTH - 1) begin
        pushWord(modelPoint(30'd600, 23'd200, 11'(100 + i)), 1'b0);
        lineCnt++;
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 30'd600, 23'd200, 11'(100 + i));
    end
    pushWord({8'h00, 8'(lineCnt)}, 1'b1);
    lineCnt = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0);
    @(negedge clk);
    checkOutput("ovf_set", overflow, 1);
    checkOutput("ovf_held_word", tdata, 16'h8660);
`ifdef COG_DROP_COUNTER_EN
    checkOutput("drop_cnt", dropCnt, 3);
`endif
    @(posedge clk); #1;
    tready = 1'b1;
    waitDrain(2000, "ovf_drain");
    checkOutput("ovf_sticky", overflow, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0, '0);
    @(negedge clk);
    checkOutput("ovf_cleared", overflow, 0);
`ifdef COG_DROP_COUNTER_EN
    checkOutput("drop_cnt_cleared", dropCnt, 0);
`endif
    @(posedge clk); #1;

    // Reset while a word is stalled: tvalid drops at once, nothing follows
    tready = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 30'd600, 23'd200, 11'd100);
    waitValid(100, n);
    checkOutput("rst_stall_valid", tvalid, 1);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_async_tvalid", tvalid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    tready = 1'b1;
    tbSof = 1'b0;
    stable = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tvalid !== 1'b0) stable = 0;
    end
    checkOutput("rst_flushed", stable, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cog_transmitter.md
Name: cog_transmitter

Overview:
- Consumer end of the CoG processing pipeline. Takes the per-figure sums, start point, point-valid strobe and the delayed line/frame markers from the processing stage.
- Computes each figure's centre-of-gravity coordinate in fixed point with a sequential divider.
- Streams the results per line over an AXI4-Stream master toward the host/DMA.

Parameters:
- FRAC_BITS, 4, fractional bits of output coordinate; legal range 0..4 (11 integer bits + FRAC_BITS ≤ 15).
- FIFO_DEPTH, 8, input entry FIFO depth; power of 2, ≥ 4.

Ports:
- i_sys_clk  in  1  clock
- i_sys_aresetn  in  1  reset
- i_sum_of_I_mult_coord  in  30  sum(I²·coord), coord 1-based within figure
- i_sum_of_I  in  23  sum(I²)
- i_start_point  in  11  column of the figure's first pixel
- i_point_is_valid  in  1  1-cycle strobe; sums and start point valid this cycle
- i_end_of_line  in  1  1-cycle line-end strobe, aligned with processing outputs
- i_end_of_frame  in  1  1-cycle frame-end strobe (informational; always coincides with i_end_of_line)
- i_new_frame  in  1  1-cycle new-frame strobe
- m_axis_tdata  out  16  output word
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready
- m_axis_tlast  out  1  last word of line
- m_axis_tuser  out  1  first word of frame
- o_overflow  out  1  sticky entry-drop flag

Behaviour:
- Clock and reset: clock i_sys_clk; reset i_sys_aresetn, asynchronous, active-low.
- Reset values: all outputs 0; FIFO empty; FSM in IDLE; line count 0; sof_pending 0.
- Entry capture:
  - Each cycle with i_point_is_valid or i_end_of_line writes one FIFO entry {has_pt, line_end, sums, start_point}.
  - Both asserted in the same cycle → a single entry with has_pt=1 and line_end=1.
- Admission: point-only entries are written only if occupancy < FIFO_DEPTH-1; entries with line_end=1 are written if occupancy < FIFO_DEPTH. Otherwise the entry is dropped and o_overflow is set.
- o_overflow clears on i_new_frame; a set on the same cycle wins.
- FSM states: IDLE, DIV, PT_OUT, TERM_OUT.
  - IDLE: if the FIFO is non-empty, pop the entry. has_pt → DIV (start divider). Otherwise → TERM_OUT.
  - DIV: restoring division of (sum_Icoord << FRAC_BITS) by sum_I, 30+FRAC_BITS iterations, 1 bit/cycle. On done → PT_OUT.
  - PT_OUT: tvalid=1, tlast=0. On tready → TERM_OUT if line_end, else IDLE.
  - TERM_OUT: tvalid=1, tlast=1. On tready → IDLE.
- Point word: tdata = {1'b1, coord[14:0]}, where coord = (start_point << F) + q − (1 << F), truncated to 15 bits, with q the quotient.
  - sum_I = 0 → q forced to 1<<F, so coord = start_point<<F.
  - Point words increment the line count (8-bit, saturating at 255).
- Terminator word: tdata = {8'h00, line_count}. Line count clears when the terminator is accepted.
- tuser: sof_pending is set by i_new_frame. The first accepted word while it is set carries tuser=1 and clears it.
- AXIS rules: tdata, tlast and tuser are held stable while tvalid && !tready. tvalid never drops without a handshake.
- Latency: an entry in an empty FIFO produces tvalid 1 (pop) + 30+F (div) + 1 cycles after capture, i.e. 36 cycles at F=4. Marker-only entries produce tvalid 2 cycles after capture.
- FIFO: simultaneous push and pop allowed; the pop frees the slot for the next cycle only.
- Reset mid-operation: division is abandoned, FIFO and stream state are flushed, tvalid drops asynchronously.

Optional Feature:
- Macro COG_DROP_COUNTER_EN.
- Defined: adds output o_drop_cnt[15:0], which counts dropped entries, saturates at 16'hFFFF, clears on i_new_frame, and resets to 0.
- Undefined: port and counter are absent; drops are reported only via o_overflow.

Decomposition:
- Package cog_pkg: entry struct typedef; FSM state enum; POINT_FLAG bit index 15; EMPTY_TERM_WORD = 16'h0000.
- Sub-module cog_divider: sequential restoring divider with start/busy/done, parameterised numerator/denominator widths, div-by-zero flag.

Test Plan:
- Single point: sums 600/200, start 100, then end_of_line, tready=1 → 0x8660 (tlast=0), then 0x0001 (tlast=1).
- Fractional: sums 650/200, start 100, with end_of_line in the same cycle → 0x8664, then 0x0001 tlast=1 from one entry.
- Empty line: i_end_of_line alone → single word 0x0000, tlast=1, 2 cycles after the strobe.
- Backpressure: tready=0 for 20 cycles during PT_OUT → tdata held at 0x8660 and tvalid held; release → both words delivered once, in order.
- Frame start: i_new_frame, then a point → first accepted word has tuser=1, later words tuser=0. sum_I=0 with start 50 → 0x8320.
- Overflow: tready=0, FIFO_DEPTH=8, 10 point strobes then end_of_line → 7 points kept, marker kept, o_overflow=1 (o_drop_cnt=3 with the macro), cleared by i_new_frame.
